raster_dispatch: RTL and testbench
==================================

# raster_dispatch

Triangle dispatcher that sits between the geometry front end and the rasterizer. Buffers incoming triangle descriptors in a small FIFO and drops zero-area triangles. Launches the remaining triangles one at a time, holding the rasterizer's input-valid for the full scan of each triangle. Tracks frame boundaries and reports frame completion with per-frame and cumulative statistics.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- tri_valid  in  1  upstream triangle valid
- tri_ready  out  1  FIFO can accept; equals !full
- tri_vert  in  288  {x1,y1,z1,x2,y2,z2,x3,y3,z3}, 32-bit signed each, x1 at [287:256]
- tri_color  in  72  {color1,color2,color3}, RGB888 each
- tri_last  in  1  sideband: triangle is last of its frame
- fb_base  in  26  framebuffer base address
- rast_vert  out  288  registered vertex bundle to rasterizer
- rast_color  out  72  registered color bundle to rasterizer
- rast_addr  out  26  latched frame base to rasterizer
- rast_valid  out  1  rasterizer in_data_valid
- rast_last  out  1  rasterizer done_in; high with last triangle of frame
- rast_busy  in  1  rasterizer stall_out; high while scanning
- rast_done  in  1  rasterizer done_out
- frame_done  out  1  one-cycle pulse at frame completion
- frame_tris  out  16  triangles launched in finished frame; valid with frame_done
- drop_count  out  16  degenerate triangles dropped since reset; saturates at 0xFFFF
- busy  out  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: push on tri_valid & tri_ready, storing {tri_vert, tri_color, tri_last}. No push when full, even on a simultaneous pop.
- Area test on the FIFO head: a = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1), computed as 33-bit signed differences and 66-bit signed products. The triangle is degenerate iff a == 0. Winding sign is not checked.
- IDLE: if the FIFO is non-empty, go to LOAD.
- LOAD (1 cycle):
  - Pop the head into rast_vert/rast_color/rast_last.
  - If no frame is open, latch fb_base into rast_addr and set frame_open.
  - If degenerate: increment drop_count. If tri_last, go to FRAME_DONE; otherwise go to IDLE.
  - Otherwise go to LAUNCH.
- LAUNCH: rast_valid=1. When rast_busy is sampled 1, increment the frame triangle counter and go to SCAN.
- SCAN: rast_valid stays 1. When rast_busy is sampled 0, go to GAP.
- GAP (1 cycle): rast_valid=0 so the rasterizer re-initialises. Then go to FLUSH if rast_last, else to IDLE.
- FLUSH: wait for rast_done=1, then go to FRAME_DONE.
- FRAME_DONE (1 cycle):
  - Assert frame_done=1 and drive frame_tris with the frame counter.
  - Clear the counter, clear frame_open and rast_last.
  - Go to IDLE.
- rast_vert/rast_color/rast_addr are stable from LOAD through GAP and change only in LOAD.
- Frame counter and drop_count saturate; they do not wrap.

## Timing
- Reset values: tri_ready=1 (FIFO empty), rast_valid=0, rast_last=0, frame_done=0, busy=0, rast_vert/rast_color/rast_addr/frame_tris/drop_count all 0, state=IDLE, frame_open=0.
- Reset asserted mid-scan: rast_valid drops asynchronously and FIFO contents are discarded.
- Push at edge N into an empty FIFO while IDLE:
  - N+1: LOAD.
  - N+2: rast_valid=1.
  - Latency from accept to launch is 2 cycles.
- Degenerate, non-last triangle: occupies 1 cycle (LOAD), then IDLE. The next triangle can be in LOAD 2 cycles later.
- Back-to-back launches: rast_valid is low for at least 2 cycles between triangles (GAP, LOAD).
- tri_ready is combinational from the registered FIFO count.
- frame_done fires exactly once per tri_last triangle. This holds when the last triangle is degenerate; in that case the pulse comes one cycle after its LOAD and the FSM does not wait for rast_done.
- rast_busy is ignored in IDLE, LOAD, GAP and FLUSH. rast_done is ignored outside FLUSH.

## Test plan
- Single valid triangle (0,0),(10,0),(0,10) with tri_last=1 and fb_base=0x100:
  - rast_valid rises 2 cycles after accept, rast_addr=0x100, rast_last=1.
  - Model busy for 20 cycles, then assert rast_done.
  - Expect one frame_done pulse with frame_tris=1.
- Degenerate triangle (0,0),(5,5),(10,10), not last:
  - Never launched; drop_count=1.
  - The following valid triangle launches normally.
- FIFO full with DEPTH=4, rasterizer held busy:
  - After 4 pushes tri_ready=0.
  - The 5th triangle is held upstream and accepted the cycle after a pop frees an entry.
  - Launch order matches push order.
- Frame of 3 triangles, the last degenerate:
  - frame_tris=2 and drop_count=1.
  - frame_done pulses without waiting for rast_done.
  - The next frame latches the new fb_base.
- Reset asserted during SCAN with 2 triangles queued:
  - Outputs take their reset values immediately.
  - After release busy=0 and no launch occurs.

Source files
------------

// File: rtl/raster_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : raster_dispatch
// Purpose  : Triangle FIFO with zero-area cull, one-at-a-time rasterizer
//            launch, and per-frame / cumulative statistics.
// Revision : 1.0
// ============================================================================
module raster_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tri_valid,
  output logic         tri_ready,
  input  logic [287:0] tri_vert,
  input  logic [71:0]  tri_color,
  input  logic         tri_last,
  input  logic [25:0]  fb_base,
  output logic [287:0] rast_vert,
  output logic [71:0]  rast_color,
  output logic [25:0]  rast_addr,
  output logic         rast_valid,
  output logic         rast_last,
  input  logic         rast_busy,
  input  logic         rast_done,
  output logic         frame_done,
  output logic [15:0]  frame_tris,
  output logic [15:0]  drop_count,
  output logic         busy
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_EW = 288 + 72 + 1;
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_LAUNCH     = 3'd2,
    S_SCAN       = 3'd3,
    S_GAP        = 3'd4,
    S_FLUSH      = 3'd5,
    S_FRAME_DONE = 3'd6
  } t_state;

  t_state r_state;

  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic [287:0] r_rast_vert;
  logic [71:0]  r_rast_color;
  logic [25:0]  r_rast_addr;
  logic         r_rast_valid;
  logic         r_rast_last;
  logic         r_frame_done;
  logic [15:0]  r_frame_tris;
  logic [15:0]  r_drop_count;
  logic [15:0]  r_tri_cnt;
  logic         r_frame_open;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full    = (r_count == c_FULL);
  assign w_push    = tri_valid & ~w_full;
  assign w_pop     = (r_state == S_LOAD);
  assign tri_ready = ~w_full;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {tri_vert, tri_color, tri_last};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-FIFO area test; only x/y of the three vertices take part.
  logic [c_EW-1:0]    w_head;
  logic [287:0]       w_hvert;
  logic [71:0]        w_hcolor;
  logic               w_hlast;
  logic signed [32:0] w_dx2, w_dy2, w_dx3, w_dy3;
  logic signed [65:0] w_p1, w_p2, w_area;
  logic               w_degen;

  assign w_head   = r_mem[r_rd_ptr];
  assign w_hvert  = w_head[c_EW-1 -: 288];
  assign w_hcolor = w_head[72:1];
  assign w_hlast  = w_head[0];

  assign w_dx2 = $signed({w_hvert[191], w_hvert[191:160]}) - $signed({w_hvert[287], w_hvert[287:256]});
  assign w_dy2 = $signed({w_hvert[159], w_hvert[159:128]}) - $signed({w_hvert[255], w_hvert[255:224]});
  assign w_dx3 = $signed({w_hvert[95],  w_hvert[95:64]})   - $signed({w_hvert[287], w_hvert[287:256]});
  assign w_dy3 = $signed({w_hvert[63],  w_hvert[63:32]})   - $signed({w_hvert[255], w_hvert[255:224]});

  assign w_p1    = 66'(w_dx2) * 66'(w_dy3);
  assign w_p2    = 66'(w_dy2) * 66'(w_dx3);
  assign w_area  = w_p1 - w_p2;
  assign w_degen = (w_area == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rast_vert  <= '0;
      r_rast_color <= '0;
      r_rast_addr  <= '0;
      r_rast_valid <= 1'b0;
      r_rast_last  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_tris <= '0;
      r_drop_count <= '0;
      r_tri_cnt    <= '0;
      r_frame_open <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_rast_vert  <= w_hvert;
          r_rast_color <= w_hcolor;
          r_rast_last  <= w_hlast;
          if (!r_frame_open) begin
            r_rast_addr  <= fb_base;
            r_frame_open <= 1'b1;
          end
          if (w_degen) begin
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            if (w_hlast) begin
              r_frame_done <= 1'b1;
              r_frame_tris <= r_tri_cnt;
              r_state      <= S_FRAME_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_rast_valid <= 1'b1;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (rast_busy) begin
            if (r_tri_cnt != 16'hFFFF) r_tri_cnt <= r_tri_cnt + 16'd1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!rast_busy) begin
            r_rast_valid <= 1'b0;
            r_state      <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= r_rast_last ? S_FLUSH : S_IDLE;
        end
        S_FLUSH: begin
          if (rast_done) begin
            r_frame_done <= 1'b1;
            r_frame_tris <= r_tri_cnt;
            r_state      <= S_FRAME_DONE;
          end
        end
        S_FRAME_DONE: begin
          r_tri_cnt    <= '0;
          r_frame_open <= 1'b0;
          r_rast_last  <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rast_vert  = r_rast_vert;
  assign rast_color = r_rast_color;
  assign rast_addr  = r_rast_addr;
  assign rast_valid = r_rast_valid;
  assign rast_last  = r_rast_last;
  assign frame_done = r_frame_done;
  assign frame_tris = r_frame_tris;
  assign drop_count = r_drop_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_raster_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_dispatch
// Purpose  : Directed table and sequence checks for raster_dispatch.
// Revision : 1.0
// ============================================================================
module tb_raster_dispatch;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         tri_valid = 1'b0;
  logic         tri_last = 1'b0;
  logic [287:0] tri_vert = '0;
  logic [71:0]  tri_color = '0;
  logic [25:0]  fb_base = '0;
  logic         rast_busy = 1'b0;
  logic         rast_done = 1'b0;
  logic         tri_ready;
  logic [287:0] rast_vert;
  logic [71:0]  rast_color;
  logic [25:0]  rast_addr;
  logic         rast_valid;
  logic         rast_last;
  logic         frame_done;
  logic [15:0]  frame_tris;
  logic [15:0]  drop_count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int          fd_cnt = 0;
  logic [15:0] fd_tris = '0;
  int          launch_cnt = 0;
  int          low_run = 100;
  logic        prev_v = 1'b0;
  logic [31:0] launch_x[$];

  int scan_len  = 4;
  int scan_left = 0;
  int done_left = 0;
  bit hold_busy = 1'b0;

  raster_dispatch #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_vert(tri_vert),
    .tri_color(tri_color), .tri_last(tri_last), .fb_base(fb_base),
    .rast_vert(rast_vert), .rast_color(rast_color), .rast_addr(rast_addr),
    .rast_valid(rast_valid), .rast_last(rast_last), .rast_busy(rast_busy),
    .rast_done(rast_done), .frame_done(frame_done), .frame_tris(frame_tris),
    .drop_count(drop_count), .busy(busy)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] mk_vert(input int x1, y1, x2, y2, x3, y3);
    return {x1, y1, 32'd7, x2, y2, 32'd9, x3, y3, 32'd11};
  endfunction

  function automatic logic [287:0] tri_at(input int k);
    return mk_vert(k, 0, k + 10, 0, k, 10);
  endfunction

  // Rasterizer model: busy for scan_len cycles per launch, done after a frame's last scan.
  initial forever begin
    @(negedge clock);
    rast_done = 1'b0;
    if (reset) begin
      rast_busy = 1'b0;
      scan_left = 0;
      done_left = 0;
    end else begin
      if (done_left > 0) begin
        done_left--;
        if (done_left == 0) rast_done = 1'b1;
      end
      if (scan_left > 0) begin
        if (!hold_busy) scan_left--;
        if (scan_left == 0) begin
          rast_busy = 1'b0;
          if (rast_last) done_left = 3;
        end
      end else if (rast_valid && !rast_busy) begin
        rast_busy = 1'b1;
        scan_left = scan_len;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (frame_done) begin
      fd_tris = frame_tris;
      fd_cnt++;
    end
    if (rast_valid && !prev_v) begin
      if (launch_cnt > 0) chk("launch_gap_ge2", 64'(low_run >= 2), 64'd1);
      launch_x.push_back(rast_vert[287:256]);
      launch_cnt++;
    end
    low_run = rast_valid ? 0 : low_run + 1;
    prev_v  = rast_valid;
  end

  task automatic push(input logic [287:0] v, input logic l);
    int waited;
    waited    = 0;
    tri_vert  = v;
    tri_color = {v[287:256], v[191:160], v[95:88]};
    tri_last  = l;
    tri_valid = 1'b1;
    while (!tri_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    chk("push_accept", 64'(tri_ready), 64'd1);
    @(negedge clock);
    tri_valid = 1'b0;
  endtask

  task automatic wait_fd(input int prev, input int budget);
    int n;
    n = 0;
    while (fd_cnt == prev && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("frame_done_seen", 64'(fd_cnt - prev), 64'd1);
  endtask

  typedef struct {
    int x1, y1, x2, y2, x3, y3;
    bit degen;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int fd0, l0, l1;
    logic [15:0]  d0;
    logic [287:0] v;

    tbl[0] = '{0, 0, 10, 0, 0, 10, 1'b0};
    tbl[1] = '{0, 0, 5, 5, 10, 10, 1'b1};
    tbl[2] = '{1, 1, 1, 1, 1, 1, 1'b1};
    tbl[3] = '{-5, 3, 7, -2, 4, 9, 1'b0};
    tbl[4] = '{0, 0, 0, 7, 0, -3, 1'b1};
    tbl[5] = '{32'sh80000000, 32'sh80000000, 32'sh7FFFFFFF, 32'sh80000000, 32'sh80000000, 32'sh7FFFFFFF, 1'b0};
    tbl[6] = '{32'sh80000000, 32'sh80000000, 0, 0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 1'b1};

    repeat (3) @(negedge clock);
    chk("rst_tri_ready",  64'(tri_ready),  64'd1);
    chk("rst_rast_valid", 64'(rast_valid), 64'd0);
    chk("rst_rast_last",  64'(rast_last),  64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_rast_vert",  64'(rast_vert != '0), 64'd0);
    chk("rst_rast_addr",  64'(rast_addr),  64'd0);
    chk("rst_frame_tris", 64'(frame_tris), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single valid last triangle: launch latency and frame completion.
    fb_base   = 26'h100;
    scan_len  = 20;
    fd0       = fd_cnt;
    v         = mk_vert(0, 0, 10, 0, 0, 10);
    tri_vert  = v;
    tri_color = 72'hFF0000_00FF00_0000FF;
    tri_last  = 1'b1;
    tri_valid = 1'b1;
    @(negedge clock);
    tri_valid = 1'b0;
    chk("t1_busy_after_accept", 64'(busy), 64'd1);
    chk("t1_valid_n", 64'(rast_valid), 64'd0);
    @(negedge clock);
    chk("t1_valid_n1", 64'(rast_valid), 64'd0);
    @(negedge clock);
    chk("t1_valid_n2", 64'(rast_valid), 64'd1);
    chk("t1_rast_addr", 64'(rast_addr), 64'h100);
    chk("t1_rast_last", 64'(rast_last), 64'd1);
    chk("t1_rast_vert", 64'(rast_vert == v), 64'd1);
    chk("t1_rast_color", 64'(rast_color == 72'hFF0000_00FF00_0000FF), 64'd1);
    wait_fd(fd0, 200);
    chk("t1_frame_tris", 64'(fd_tris), 64'd1);
    repeat (5) @(negedge clock);
    chk("t1_single_pulse", 64'(fd_cnt - fd0), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_last_cleared", 64'(rast_last), 64'd0);

    // Area table: each entry is a one-triangle frame.
    scan_len = 4;
    for (int i = 0; i < 7; i++) begin
      fd0     = fd_cnt;
      l0      = launch_cnt;
      d0      = drop_count;
      fb_base = 26'h200 + 26'(i);
      push(mk_vert(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].x3, tbl[i].y3), 1'b1);
      wait_fd(fd0, 200);
      chk($sformatf("tbl%0d_frame_tris", i), 64'(fd_tris), tbl[i].degen ? 64'd0 : 64'd1);
      chk($sformatf("tbl%0d_drop_count", i), 64'(drop_count), 64'(d0) + (tbl[i].degen ? 64'd1 : 64'd0));
      chk($sformatf("tbl%0d_launches", i), 64'(launch_cnt - l0), tbl[i].degen ? 64'd0 : 64'd1);
      chk($sformatf("tbl%0d_rast_addr", i), 64'(rast_addr), 64'h200 + 64'(i));
      repeat (3) @(negedge clock);
    end

    // Degenerate non-last followed by a valid last.
    fd0 = fd_cnt; l0 = launch_cnt; d0 = drop_count;
    fb_base = 26'h150;
    push(mk_vert(0, 0, 5, 5, 10, 10), 1'b0);
    push(tri_at(20), 1'b1);
    wait_fd(fd0, 200);
    chk("dg_drop_count", 64'(drop_count), 64'(d0) + 64'd1);
    chk("dg_launches", 64'(launch_cnt - l0), 64'd1);
    chk("dg_launch_x", 64'(launch_x[launch_x.size() - 1]), 64'd20);
    chk("dg_frame_tris", 64'(fd_tris), 64'd1);
    repeat (3) @(negedge clock);

    // FIFO full with the rasterizer held busy.
    fd0 = fd_cnt; l0 = launch_cnt;
    scan_len  = 3;
    hold_busy = 1'b1;
    push(tri_at(100), 1'b0);
    repeat (3) @(negedge clock);
    chk("ff_scanning", 64'(rast_busy && rast_valid), 64'd1);
    for (int k = 2; k <= 5; k++) push(tri_at(100 * k), 1'b0);
    chk("ff_full_ready", 64'(tri_ready), 64'd0);
    tri_vert  = tri_at(600);
    tri_last  = 1'b1;
    tri_valid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("ff_held_ready", 64'(tri_ready), 64'd0);
    end
    hold_busy = 1'b0;
    push(tri_at(600), 1'b1);
    wait_fd(fd0, 500);
    chk("ff_frame_tris", 64'(fd_tris), 64'd6);
    chk("ff_launches", 64'(launch_cnt - l0), 64'd6);
    for (int j = 0; j < 6; j++) begin
      if (l0 + j < launch_x.size())
        chk($sformatf("ff_order%0d", j), 64'(launch_x[l0 + j]), 64'(100 * (j + 1)));
    end
    repeat (3) @(negedge clock);

    // Three-triangle frame ending in a degenerate; then a new frame base.
    fd0 = fd_cnt; l0 = launch_cnt; d0 = drop_count;
    fb_base = 26'h300;
    push(tri_at(700), 1'b0);
    push(tri_at(800), 1'b0);
    push(mk_vert(0, 0, 5, 5, 10, 10), 1'b1);
    fb_base = 26'h3FF;
    wait_fd(fd0, 200);
    chk("f3_frame_tris", 64'(fd_tris), 64'd2);
    chk("f3_drop_count", 64'(drop_count), 64'(d0) + 64'd1);
    chk("f3_launches", 64'(launch_cnt - l0), 64'd2);
    chk("f3_rast_addr", 64'(rast_addr), 64'h300);
    repeat (3) @(negedge clock);
    fd0 = fd_cnt;
    push(tri_at(900), 1'b1);
    wait_fd(fd0, 200);
    chk("f4_rast_addr", 64'(rast_addr), 64'h3FF);
    chk("f4_frame_tris", 64'(fd_tris), 64'd1);
    repeat (3) @(negedge clock);

    // Reset during a scan with two triangles queued.
    hold_busy = 1'b1;
    push(tri_at(1000), 1'b0);
    repeat (3) @(negedge clock);
    chk("rs_scanning", 64'(rast_valid), 64'd1);
    push(tri_at(1100), 1'b0);
    push(tri_at(1200), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_valid_async", 64'(rast_valid), 64'd0);
    chk("rs_tri_ready", 64'(tri_ready), 64'd1);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_rast_addr", 64'(rast_addr), 64'd0);
    chk("rs_rast_vert", 64'(rast_vert != '0), 64'd0);
    chk("rs_drop_count", 64'(drop_count), 64'd0);
    chk("rs_rast_last", 64'(rast_last), 64'd0);
    hold_busy = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    l1 = launch_cnt;
    repeat (10) @(negedge clock);
    chk("rs_post_busy", 64'(busy), 64'd0);
    chk("rs_post_launch", 64'(launch_cnt - l1), 64'd0);
    chk("rs_post_valid", 64'(rast_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
